// File: rtl/alu_regfile_pkg.sv
// alu_regfile_pkg: shared definitions for the pipelined register-file + ALU
// datapath (alu_regfile_pipe, alu_core).
//   alu_op_t : 3-bit ALU operation code, values ALU_ADD .. ALU_BNE.
package alu_regfile_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_BEQ = 3'b110,
    ALU_BNE = 3'b111
  } alu_op_t;

endpackage

// File: rtl/alu_core.sv
// alu_core: purely combinational ALU.
//   a, b        in  DATA_W  operands
//   op          in  alu_op_t operation
//   result      out DATA_W  result, modulo 2^DATA_W
//   ovf         out 1       signed overflow (ADD, SUB, BEQ, BNE only)
//   take_branch out 1       branch condition (BEQ, BNE only)
module alu_core
  import alu_regfile_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_op_t           op,
  output logic [DATA_W-1:0] result,
  output logic              ovf,
  output logic              take_branch
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W-1:0] sum, diff;
  logic              add_ovf, sub_ovf, lt;

  assign sum     = a + b;
  assign diff    = a - b;
  assign add_ovf = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
  assign sub_ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
  assign lt      = $signed(a) < $signed(b);

  always_comb begin
    result      = '0;
    ovf         = 1'b0;
    take_branch = 1'b0;
    case (op)
      ALU_ADD: begin result = sum;  ovf = add_ovf; end
      ALU_SUB: begin result = diff; ovf = sub_ovf; end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SLT: result = {{(DATA_W-1){1'b0}}, lt};
      // branches still report A-B so the compare is visible downstream
      ALU_BEQ: begin result = diff; ovf = sub_ovf; take_branch = (a == b); end
      ALU_BNE: begin result = diff; ovf = sub_ovf; take_branch = (a != b); end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_regfile_pipe.sv
// alu_regfile_pipe: two-stage register-file + ALU pipeline with valid/ready
// on both sides. S1 latches muxed operands, S2 latches the ALU output; the
// register file is written from the S1 ALU output as S1 advances into S2.
// Optional macro ALU_REGFILE_FWD_EN: bypass the S1 ALU output into the
// operand mux instead of stalling issue on a read-after-write hazard.
//   clk, rst (async, active-low)
//   in_valid/in_ready, rd_addr1, rd_addr2, wr_addr, reg_write,
//   alu_src1 (1: A=0), alu_src2 (1: B=imm), imm, alu_op   -- issue side
//   out_valid/out_ready, result, input1, input2, ovf, take_branch -- result side
module alu_regfile_pipe
  import alu_regfile_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int REG_CNT = 4,
  parameter int ADDR_W  = $clog2(REG_CNT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              reg_write,
  input  logic              alu_src1,
  input  logic              alu_src2,
  input  logic [DATA_W-1:0] imm,
  input  logic [2:0]        alu_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] input1,
  output logic [DATA_W-1:0] input2,
  output logic              ovf,
  output logic              take_branch
);

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    alu_op_t           op;
    logic              reg_write;
    logic [ADDR_W-1:0] wr_addr;
  } s1_t;

  logic [REG_CNT-1:0][DATA_W-1:0] rf;
  s1_t               s1;
  logic              s1_valid, s2_valid;
  logic              s1_en, s2_en, accept, hazard;
  logic              haz1, haz2;
  logic [DATA_W-1:0] op_a, op_b;
  logic [DATA_W-1:0] alu_res;
  logic              alu_ovf, alu_br;

  alu_core #(.DATA_W(DATA_W)) u_alu (
    .a(s1.a), .b(s1.b), .op(s1.op),
    .result(alu_res), .ovf(alu_ovf), .take_branch(alu_br)
  );

  assign s2_en     = !s2_valid || out_ready;
  assign s1_en     = !s1_valid || s2_en;
  assign in_ready  = s1_en && !hazard;
  assign accept    = in_valid && in_ready;
  assign out_valid = s2_valid;

  // a read of a register that the op in S1 is about to write
  assign haz1 = s1_valid && s1.reg_write && !alu_src1 && (s1.wr_addr == rd_addr1);
  assign haz2 = s1_valid && s1.reg_write && !alu_src2 && (s1.wr_addr == rd_addr2);

`ifdef ALU_REGFILE_FWD_EN
  // accept only happens when S1 advances on the same edge, so the bypassed
  // value is exactly what lands in the register file.
  assign hazard = 1'b0;
  assign op_a   = alu_src1 ? '0  : (haz1 ? alu_res : rf[rd_addr1]);
  assign op_b   = alu_src2 ? imm : (haz2 ? alu_res : rf[rd_addr2]);
`else
  assign hazard = haz1 || haz2;
  assign op_a   = alu_src1 ? '0  : rf[rd_addr1];
  assign op_b   = alu_src2 ? imm : rf[rd_addr2];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf          <= '0;
      s1          <= '0;
      s1_valid    <= 1'b0;
      s2_valid    <= 1'b0;
      result      <= '0;
      input1      <= '0;
      input2      <= '0;
      ovf         <= 1'b0;
      take_branch <= 1'b0;
    end else begin
      if (s2_en) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          result      <= alu_res;
          input1      <= s1.a;
          input2      <= s1.b;
          ovf         <= alu_ovf;
          take_branch <= alu_br;
        end
      end
      // write-back is tied to S1 advancing so a stalled op writes only once
      if (s1_valid && s2_en && s1.reg_write)
        rf[s1.wr_addr] <= alu_res;
      if (s1_en) begin
        s1_valid <= accept;
        if (accept)
          s1 <= '{a: op_a, b: op_b, op: alu_op_t'(alu_op),
                  reg_write: reg_write, wr_addr: wr_addr};
      end
    end
  end

endmodule

// File: tb/tb_alu_regfile_pipe.sv
module tb_alu_regfile_pipe;

  logic       clk, rst;
  logic       in_valid, in_ready, reg_write, alu_src1, alu_src2;
  logic [1:0] rd_addr1, rd_addr2, wr_addr;
  logic [7:0] imm, result, input1, input2;
  logic [2:0] alu_op;
  logic       out_valid, out_ready, ovf, take_branch;

  alu_regfile_pipe #(.DATA_W(8), .REG_CNT(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .wr_addr(wr_addr),
    .reg_write(reg_write), .alu_src1(alu_src1), .alu_src2(alu_src2),
    .imm(imm), .alu_op(alu_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .input1(input1), .input2(input2),
    .ovf(ovf), .take_branch(take_branch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_SLT = 3'd5,
                         OP_BEQ = 3'd6, OP_BNE = 3'd7;

  typedef struct {
    logic [7:0] res, a, b;
    logic       ovf, br;
  } exp_t;

  exp_t       q[$];
  logic [7:0] mregs[4];
  int         errors = 0, checks = 0;
  bit         accepted, hold;
  logic [7:0] h_res, h_in1, h_in2;
  logic [7:0] last_res;
  logic       last_ovf, last_br;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // Sequential-semantics reference: arithmetic on signed integers.
  function automatic exp_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int sa, sb, r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    e.a = a; e.b = b; e.ovf = 1'b0; e.br = 1'b0;
    r = 0;
    case (op)
      3'd0: begin r = sa + sb; e.ovf = (r > 127) || (r < -128); end
      3'd1: begin r = sa - sb; e.ovf = (r > 127) || (r < -128); end
      3'd2: r = int'(a & b);
      3'd3: r = int'(a | b);
      3'd4: r = int'(a ^ b);
      3'd5: r = (sa < sb) ? 1 : 0;
      3'd6: begin r = sa - sb; e.ovf = (r > 127) || (r < -128); e.br = (a == b); end
      default: begin r = sa - sb; e.ovf = (r > 127) || (r < -128); e.br = (a != b); end
    endcase
    e.res = r[7:0];
    return e;
  endfunction

  // One cycle: sample at the negedge phase (+1), score, then wait next negedge.
  task automatic cyc();
    exp_t e;
    logic [7:0] a, b;
    #1;
    if (hold) begin
      check("hold_result", result, h_res);
      check("hold_input1", input1, h_in1);
      check("hold_input2", input2, h_in2);
    end
    hold  = out_valid && !out_ready;
    h_res = result; h_in1 = input1; h_in2 = input2;
    if (out_valid && out_ready) begin
      if (q.size() == 0) check("spurious_out", out_valid, 0);
      else begin
        e = q.pop_front();
        check("result", result, e.res);
        check("input1", input1, e.a);
        check("input2", input2, e.b);
        check("ovf", ovf, e.ovf);
        check("take_branch", take_branch, e.br);
        last_res = result; last_ovf = ovf; last_br = take_branch;
      end
    end
    accepted = in_valid && in_ready;
    if (accepted) begin
      a = alu_src1 ? 8'h00 : mregs[rd_addr1];
      b = alu_src2 ? imm : mregs[rd_addr2];
      e = model(alu_op, a, b);
      q.push_back(e);
      if (reg_write) mregs[wr_addr] = e.res;
    end
    @(negedge clk);
  endtask

  task automatic issue(input logic [2:0] op, input logic [1:0] wa, input logic [1:0] ra1,
                       input logic [1:0] ra2, input bit rw, input bit s1, input bit s2,
                       input logic [7:0] im, output int waits);
    alu_op = op; wr_addr = wa; rd_addr1 = ra1; rd_addr2 = ra2;
    reg_write = rw; alu_src1 = s1; alu_src2 = s2; imm = im; in_valid = 1'b1;
    waits = 0;
    cyc();
    while (!accepted) begin
      waits++;
      if (waits > 40) begin
        check("issue_timeout", waits, 0);
        break;
      end
      cyc();
    end
    in_valid = 1'b0;
  endtask

  task automatic wr(input logic [1:0] r, input logic [7:0] v);
    int w;
    issue(OP_ADD, r, 2'd0, 2'd0, 1'b1, 1'b1, 1'b1, v, w);
  endtask

  task automatic rdreg(input logic [1:0] r);
    int w;
    issue(OP_ADD, 2'd0, r, 2'd0, 1'b0, 1'b0, 1'b1, 8'h00, w);
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0; out_ready = 1'b1;
    while ((q.size() != 0 || out_valid) && n < 30) begin
      cyc();
      n++;
    end
    check("drain_empty", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; reg_write = 1'b0;
    alu_src1 = 1'b0; alu_src2 = 1'b0; imm = '0; alu_op = '0;
    rd_addr1 = '0; rd_addr2 = '0; wr_addr = '0;
    hold = 1'b0; last_res = '0; last_ovf = 1'b0; last_br = 1'b0;
    for (int i = 0; i < 4; i++) mregs[i] = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // reset with two ops in flight
    out_ready = 1'b0;
    wr(2'd1, 8'h55);
    wr(2'd2, 8'h66);
    #3 rst = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_result", result, 0);
    check("midrst_input1", input1, 0);
    check("midrst_input2", input2, 0);
    check("midrst_ovf", ovf, 0);
    check("midrst_take_branch", take_branch, 0);
    q.delete();
    hold = 1'b0;
    for (int i = 0; i < 4; i++) mregs[i] = 8'h00;
    @(negedge clk);
    rst = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    rdreg(2'd1);
    drain();
    check("rst_r1_zero", last_res, 8'h00);

    // dependent back-to-back
    issue(OP_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 1'b1, 1'b1, 8'h05, w);
    issue(OP_ADD, 2'd2, 2'd1, 2'd0, 1'b1, 1'b0, 1'b1, 8'h03, w);
`ifdef ALU_REGFILE_FWD_EN
    check("dep_stall_cycles", w, 0);
`else
    check("dep_stall_cycles", w, 1);
`endif
    drain();
    check("dep_result", last_res, 8'h08);

    // overflow
    wr(2'd1, 8'h7F);
    issue(OP_ADD, 2'd2, 2'd1, 2'd0, 1'b1, 1'b0, 1'b1, 8'h01, w);
    drain();
    check("add_ovf_result", last_res, 8'h80);
    check("add_ovf_flag", last_ovf, 1);
    issue(OP_SUB, 2'd2, 2'd2, 2'd0, 1'b1, 1'b0, 1'b1, 8'h01, w);
    drain();
    check("sub_ovf_result", last_res, 8'h7F);
    check("sub_ovf_flag", last_ovf, 1);

    // backpressure: two accepted, third blocked, first result held
    out_ready = 1'b0;
    issue(OP_ADD, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1, 8'h11, w);
    check("bp_acc1_wait", w, 0);
    issue(OP_ADD, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1, 8'h22, w);
    check("bp_acc2_wait", w, 0);
    alu_op = OP_ADD; alu_src1 = 1'b1; alu_src2 = 1'b1; reg_write = 1'b0;
    imm = 8'h33; in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      check("bp_blocked", accepted, 0);
      check("bp_first_held", result, 8'h11);
    end
    out_ready = 1'b1;
    issue(OP_ADD, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1, 8'h33, w);
    drain();
    check("bp_last_result", last_res, 8'h33);

    // branches
    wr(2'd1, 8'h80);
    issue(OP_BEQ, 2'd0, 2'd1, 2'd0, 1'b0, 1'b0, 1'b1, 8'h80, w);
    drain();
    check("beq_take", last_br, 1);
    check("beq_result", last_res, 8'h00);
    issue(OP_BNE, 2'd0, 2'd1, 2'd0, 1'b0, 1'b0, 1'b1, 8'h80, w);
    drain();
    check("bne_take", last_br, 0);
    for (int r = 0; r < 4; r++) rdreg(r[1:0]);
    drain();

    // SLT and suppressed write
    wr(2'd1, 8'hFF);
    issue(OP_SLT, 2'd0, 2'd1, 2'd0, 1'b0, 1'b0, 1'b1, 8'h01, w);
    drain();
    check("slt_result", last_res, 8'h01);
    issue(OP_ADD, 2'd3, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1, 8'h42, w);
    rdreg(2'd3);
    drain();
    check("r3_unwritten", last_res, 8'h00);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      alu_op    = 3'($urandom);
      wr_addr   = 2'($urandom);
      rd_addr1  = 2'($urandom);
      rd_addr2  = 2'($urandom);
      reg_write = 1'($urandom);
      alu_src1  = ($urandom_range(0, 3) == 0);
      alu_src2  = 1'($urandom);
      imm       = 8'($urandom);
      cyc();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
